// File: rtl/iiq_issue_select.sv
// Integer issue queue consumer: tag wakeup, oldest-ready select
// and a single-entry issue register toward the integer ALU.
`ifndef IIQ_N_ENTRIES
`define IIQ_N_ENTRIES 8
`endif

module iiq_issue_select #(
  parameter int N_ENTRIES     = `IIQ_N_ENTRIES,
  parameter int TAG_WIDTH     = 6,
  parameter int PAYLOAD_WIDTH = 32,
  parameter int ENTRY_WIDTH   =
    3*TAG_WIDTH+2+PAYLOAD_WIDTH
) (
  input  logic clk,
  input  logic rst_aL,
  input  logic flush,
  input  logic [N_ENTRIES-1:0] entry_valid,
  input  logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]
    entry_douts,
  input  logic deq_valid,
  input  logic [ENTRY_WIDTH-1:0] deq_data,
  output logic deq_ready,
  output logic [N_ENTRIES-1:0] deq_sel_onehot,
  output logic [N_ENTRIES-1:0] wr_en,
  output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]
    wr_data,
  input  logic cdb_valid,
  input  logic [TAG_WIDTH-1:0] cdb_tag,
  output logic iss_valid,
  input  logic iss_ready,
  output logic [TAG_WIDTH-1:0] iss_dst_tag,
  output logic [PAYLOAD_WIDTH-1:0] iss_payload,
  output logic bcast_valid,
  output logic [TAG_WIDTH-1:0] bcast_tag
);

  // Field positions, MSB->LSB:
  // {src1_rdy, src1_tag, src2_rdy, src2_tag, dst_tag, payload}
  localparam int P_DST = PAYLOAD_WIDTH;
  localparam int P_S2T = P_DST + TAG_WIDTH;
  localparam int P_S2R = P_S2T + TAG_WIDTH;
  localparam int P_S1T = P_S2R + 1;
  localparam int P_S1R = P_S1T + TAG_WIDTH;

  logic r_iss_valid;
  logic [TAG_WIDTH-1:0] r_iss_dst;
  logic [PAYLOAD_WIDTH-1:0] r_iss_pay;
  logic r_bcast_valid;
  logic [TAG_WIDTH-1:0] r_bcast_tag;

  logic [N_ENTRIES-1:0] w_elig;
  logic [N_ENTRIES-1:0] w_wake;
  logic [N_ENTRIES-1:0] w_lowest;
  logic w_any;
  logic w_slot_free;
  logic w_deq_ready;
  logic w_fire;
  logic [TAG_WIDTH-1:0] w_deq_dst;
  logic [PAYLOAD_WIDTH-1:0] w_deq_pay;
  logic w_unused_src;

  // Per-entry wakeup match and ready-bit update.
  for (genvar gi = 0; gi < N_ENTRIES; gi++) begin : g_ent
    logic w_s1_rdy;
    logic w_s2_rdy;
    logic [TAG_WIDTH-1:0] w_s1_tag;
    logic [TAG_WIDTH-1:0] w_s2_tag;
    logic w_s1_hit;
    logic w_s2_hit;
    logic w_s1_set;
    logic w_s2_set;

    assign w_s1_rdy = entry_douts[gi][P_S1R];
    assign w_s2_rdy = entry_douts[gi][P_S2R];
    assign w_s1_tag =
      entry_douts[gi][P_S1T +: TAG_WIDTH];
    assign w_s2_tag =
      entry_douts[gi][P_S2T +: TAG_WIDTH];

    assign w_s1_hit =
      (cdb_valid && (w_s1_tag == cdb_tag)) ||
      (r_bcast_valid && (w_s1_tag == r_bcast_tag));
    assign w_s2_hit =
      (cdb_valid && (w_s2_tag == cdb_tag)) ||
      (r_bcast_valid && (w_s2_tag == r_bcast_tag));

    assign w_s1_set =
      entry_valid[gi] & ~w_s1_rdy & w_s1_hit;
    assign w_s2_set =
      entry_valid[gi] & ~w_s2_rdy & w_s2_hit;

    assign w_wake[gi] = w_s1_set | w_s2_set;

    // Stored bits only: a same-cycle wakeup waits a cycle.
    assign w_elig[gi] =
      entry_valid[gi] & w_s1_rdy & w_s2_rdy;

    always_comb begin
      wr_data[gi] = entry_douts[gi];
      wr_data[gi][P_S1R] = w_s1_rdy | w_s1_set;
      wr_data[gi][P_S2R] = w_s2_rdy | w_s2_set;
    end
  end

  assign w_any = |w_elig;
  assign w_lowest =
    w_elig & (~w_elig + N_ENTRIES'(1));

  assign w_slot_free = ~r_iss_valid | iss_ready;
  assign w_deq_ready =
    rst_aL & w_slot_free & w_any & ~flush;
  assign w_fire = w_deq_ready & deq_valid;

  assign w_deq_dst = deq_data[P_DST +: TAG_WIDTH];
  assign w_deq_pay = deq_data[PAYLOAD_WIDTH-1:0];
  assign w_unused_src = ^deq_data[ENTRY_WIDTH-1:P_S2T];

  assign deq_ready = w_deq_ready;
  assign deq_sel_onehot =
    w_deq_ready ? w_lowest : '0;

  // The entry leaving this cycle must not be rewritten.
  assign wr_en =
    rst_aL ? (w_wake & ~deq_sel_onehot) : '0;

  // Issue register and registered self-wakeup broadcast.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      r_iss_valid   <= 1'b0;
      r_iss_dst     <= '0;
      r_iss_pay     <= '0;
      r_bcast_valid <= 1'b0;
      r_bcast_tag   <= '0;
    end else begin
      if (flush) begin
        r_iss_valid <= 1'b0;
      end else if (w_fire) begin
        r_iss_valid <= 1'b1;
      end else if (iss_ready) begin
        r_iss_valid <= 1'b0;
      end
      if (w_fire) begin
        r_iss_dst   <= w_deq_dst;
        r_iss_pay   <= w_deq_pay;
        r_bcast_tag <= w_deq_dst;
      end
      r_bcast_valid <= w_fire & ~flush;
    end
  end

  assign iss_valid   = r_iss_valid;
  assign iss_dst_tag = r_iss_dst;
  assign iss_payload = r_iss_pay;
  assign bcast_valid = r_bcast_valid;
  assign bcast_tag   = r_bcast_tag;

endmodule

// File: tb/tb_iiq_issue_select.sv
// Directed bench for iiq_issue_select: combinational
// vector table plus multi-cycle issue sequences.
module tb_iiq_issue_select;

  localparam int N  = 8;
  localparam int TW = 6;
  localparam int PW = 32;
  localparam int EW = 3*TW+2+PW;

  logic clk = 1'b0;
  logic rst_aL;
  logic flush;
  logic [N-1:0] entry_valid;
  logic [N-1:0][EW-1:0] entry_douts;
  logic deq_valid;
  logic [EW-1:0] deq_data;
  logic deq_ready;
  logic [N-1:0] deq_sel_onehot;
  logic [N-1:0] wr_en;
  logic [N-1:0][EW-1:0] wr_data;
  logic cdb_valid;
  logic [TW-1:0] cdb_tag;
  logic iss_valid;
  logic iss_ready;
  logic [TW-1:0] iss_dst_tag;
  logic [PW-1:0] iss_payload;
  logic bcast_valid;
  logic [TW-1:0] bcast_tag;

  iiq_issue_select #(
    .N_ENTRIES(N), .TAG_WIDTH(TW),
    .PAYLOAD_WIDTH(PW), .ENTRY_WIDTH(EW)
  ) dut (
    .clk(clk), .rst_aL(rst_aL), .flush(flush),
    .entry_valid(entry_valid),
    .entry_douts(entry_douts),
    .deq_valid(deq_valid), .deq_data(deq_data),
    .deq_ready(deq_ready),
    .deq_sel_onehot(deq_sel_onehot),
    .wr_en(wr_en), .wr_data(wr_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_dst_tag(iss_dst_tag),
    .iss_payload(iss_payload),
    .bcast_valid(bcast_valid), .bcast_tag(bcast_tag)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    logic [N-1:0] ev;
    logic [N-1:0][EW-1:0] d;
    logic cv;
    logic [TW-1:0] ct;
    logic fl;
    logic ir;
    logic edr;
    logic [N-1:0] esel;
    logic [N-1:0] ewr;
    logic [N-1:0][EW-1:0] ewd;
  } vec_t;

  localparam int NV = 12;
  vec_t tv[NV];

  function automatic logic [EW-1:0] mk(
    input logic s1r, input logic [TW-1:0] s1t,
    input logic s2r, input logic [TW-1:0] s2t,
    input logic [TW-1:0] dst, input logic [PW-1:0] pay);
    return {s1r, s1t, s2r, s2t, dst, pay};
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm,
                      input logic [N*EW-1:0] act,
                      input logic [N*EW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  logic [EW-1:0] e_nr;
  logic [EW-1:0] e_rdy;

  task automatic clr();
    entry_valid = '0;
    for (int j = 0; j < N; j++) entry_douts[j] = e_nr;
    deq_valid = 1'b0;
    deq_data = '0;
    cdb_valid = 1'b0;
    cdb_tag = '0;
    flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1);
  end

  initial begin
    e_nr  = mk(1'b0, 6'd60, 1'b0, 6'd61, 6'd1, 32'h0);
    e_rdy = mk(1'b1, 6'd1, 1'b1, 6'd2, 6'd3, 32'h1111);

    for (int k = 0; k < NV; k++) begin
      tv[k].ev = '0;
      for (int j = 0; j < N; j++) tv[k].d[j] = e_nr;
      tv[k].cv = 1'b0;
      tv[k].ct = '0;
      tv[k].fl = 1'b0;
      tv[k].ir = 1'b1;
      tv[k].edr = 1'b0;
      tv[k].esel = '0;
      tv[k].ewr = '0;
    end
    // empty queue, stale ready data, cdb hits idle tags
    tv[0].d[0] = e_rdy;
    tv[0].cv = 1'b1; tv[0].ct = 6'd60;
    // one ready entry, free slot via !iss_valid
    tv[1].ev = 8'h01; tv[1].d[0] = e_rdy;
    tv[1].ir = 1'b0;
    tv[1].edr = 1'b1; tv[1].esel = 8'h01;
    // ready entry behind non-ready ones
    tv[2].ev = 8'h0F; tv[2].d[3] = e_rdy;
    tv[2].edr = 1'b1; tv[2].esel = 8'h08;
    // all ready: oldest wins
    tv[3].ev = 8'hFF;
    for (int j = 0; j < N; j++) tv[3].d[j] = e_rdy;
    tv[3].edr = 1'b1; tv[3].esel = 8'h01;
    // only youngest ready
    tv[4].ev = 8'hFF; tv[4].d[7] = e_rdy;
    tv[4].edr = 1'b1; tv[4].esel = 8'h80;
    // ready but invalid slot 0 is skipped
    tv[5].ev = 8'h3E;
    tv[5].d[0] = e_rdy; tv[5].d[5] = e_rdy;
    tv[5].edr = 1'b1; tv[5].esel = 8'h20;
    // flush blocks dequeue
    tv[6].ev = 8'h01; tv[6].d[0] = e_rdy;
    tv[6].fl = 1'b1;
    // both sources share tag 12, one write sets both
    tv[7].ev = 8'h07;
    tv[7].d[2] = mk(1'b0, 6'd12, 1'b0, 6'd12, 6'd4,
                    32'h2222);
    tv[7].cv = 1'b1; tv[7].ct = 6'd12;
    tv[7].ewr = 8'h04;
    // same match on an invalid slot: no write
    tv[8].ev = 8'h03;
    tv[8].d[2] = tv[7].d[2];
    tv[8].cv = 1'b1; tv[8].ct = 6'd12;
    // tag 0 is an ordinary tag
    tv[9].ev = 8'h02;
    tv[9].d[1] = mk(1'b0, 6'd0, 1'b1, 6'd5, 6'd6,
                    32'h3333);
    tv[9].cv = 1'b1; tv[9].ct = 6'd0;
    tv[9].ewr = 8'h02;
    // dequeue and wakeup in the same cycle
    tv[10].ev = 8'h03; tv[10].d[0] = e_rdy;
    tv[10].d[1] = mk(1'b1, 6'd20, 1'b0, 6'd21, 6'd8,
                     32'h4444);
    tv[10].cv = 1'b1; tv[10].ct = 6'd21;
    tv[10].edr = 1'b1; tv[10].esel = 8'h01;
    tv[10].ewr = 8'h02;
    // matching tag but cdb_valid low
    tv[11].ev = 8'h01;
    tv[11].d[0] = mk(1'b0, 6'd12, 1'b1, 6'd5, 6'd9,
                     32'h5555);
    tv[11].ct = 6'd12;

    for (int k = 0; k < NV; k++) tv[k].ewd = tv[k].d;
    tv[7].ewd[2] = mk(1'b1, 6'd12, 1'b1, 6'd12, 6'd4,
                      32'h2222);
    tv[9].ewd[1] = mk(1'b1, 6'd0, 1'b1, 6'd5, 6'd6,
                      32'h3333);
    tv[10].ewd[1] = mk(1'b1, 6'd20, 1'b1, 6'd21, 6'd8,
                       32'h4444);

    // Reset with inputs that would otherwise act
    rst_aL = 1'b0;
    iss_ready = 1'b1;
    clr();
    entry_valid = 8'h03;
    entry_douts[0] = e_rdy;
    entry_douts[1] = mk(1'b0, 6'd33, 1'b1, 6'd2, 6'd4,
                        32'h0);
    deq_valid = 1'b1;
    deq_data = e_rdy;
    cdb_valid = 1'b1;
    cdb_tag = 6'd33;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst iss_valid", 64'(iss_valid), 64'd0);
    chk("rst iss_dst", 64'(iss_dst_tag), 64'd0);
    chk("rst iss_payload", 64'(iss_payload), 64'd0);
    chk("rst bcast_valid", 64'(bcast_valid), 64'd0);
    chk("rst bcast_tag", 64'(bcast_tag), 64'd0);
    chk("rst deq_ready", 64'(deq_ready), 64'd0);
    chk("rst sel", 64'(deq_sel_onehot), 64'd0);
    chk("rst wr_en", 64'(wr_en), 64'd0);
    @(negedge clk);
    clr();
    rst_aL = 1'b1;

    // Combinational table, no dequeue handshake
    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      entry_valid = tv[k].ev;
      entry_douts = tv[k].d;
      cdb_valid = tv[k].cv;
      cdb_tag = tv[k].ct;
      flush = tv[k].fl;
      iss_ready = tv[k].ir;
      deq_valid = 1'b0;
      #1;
      chk($sformatf("vec%0d deq_ready", k),
          64'(deq_ready), 64'(tv[k].edr));
      chk($sformatf("vec%0d sel", k),
          64'(deq_sel_onehot), 64'(tv[k].esel));
      chk($sformatf("vec%0d wr_en", k),
          64'(wr_en), 64'(tv[k].ewr));
      chkw($sformatf("vec%0d wr_data", k),
           wr_data, tv[k].ewd);
    end

    // Basic issue of a ready entry
    @(negedge clk);
    clr();
    iss_ready = 1'b1;
    entry_valid = 8'h01;
    entry_douts[0] = mk(1'b1, 6'd1, 1'b1, 6'd2, 6'd5,
                        32'hA5A5A5A5);
    deq_valid = 1'b1;
    deq_data = entry_douts[0];
    #1;
    chk("s1 deq_ready", 64'(deq_ready), 64'd1);
    chk("s1 sel", 64'(deq_sel_onehot), 64'h01);
    @(negedge clk);
    clr();
    #1;
    chk("s1 iss_valid", 64'(iss_valid), 64'd1);
    chk("s1 payload", 64'(iss_payload), 64'hA5A5A5A5);
    chk("s1 dst", 64'(iss_dst_tag), 64'd5);
    chk("s1 bcast_valid", 64'(bcast_valid), 64'd1);
    chk("s1 bcast_tag", 64'(bcast_tag), 64'd5);
    chk("s1 idle deq_ready", 64'(deq_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("s1 drain iss_valid", 64'(iss_valid), 64'd0);
    chk("s1 drain bcast", 64'(bcast_valid), 64'd0);

    // Oldest-first, then shifted entry selected
    @(negedge clk);
    clr();
    entry_valid = 8'h07;
    entry_douts[0] = mk(1'b1, 6'd1, 1'b1, 6'd2, 6'd10,
                        32'hB0);
    entry_douts[1] = mk(1'b0, 6'd40, 1'b1, 6'd2, 6'd11,
                        32'hB1);
    entry_douts[2] = mk(1'b1, 6'd3, 1'b1, 6'd4, 6'd12,
                        32'hB2);
    deq_valid = 1'b1;
    deq_data = entry_douts[0];
    #1;
    chk("s2 sel first", 64'(deq_sel_onehot), 64'h01);
    @(negedge clk);
    entry_valid = 8'h03;
    entry_douts[0] = mk(1'b0, 6'd40, 1'b1, 6'd2, 6'd11,
                        32'hB1);
    entry_douts[1] = mk(1'b1, 6'd3, 1'b1, 6'd4, 6'd12,
                        32'hB2);
    entry_douts[2] = e_nr;
    deq_data = entry_douts[1];
    #1;
    chk("s2 sel second", 64'(deq_sel_onehot), 64'h02);
    chk("s2 payload first", 64'(iss_payload), 64'hB0);
    @(negedge clk);
    entry_valid = 8'h01;
    entry_douts[1] = e_nr;
    deq_valid = 1'b0;
    #1;
    chk("s2 payload second", 64'(iss_payload), 64'hB2);
    chk("s2 dst second", 64'(iss_dst_tag), 64'd12);
    @(negedge clk);
    clr();

    // CDB wakeup, selected one cycle later
    @(negedge clk);
    clr();
    entry_valid = 8'h01;
    entry_douts[0] = mk(1'b0, 6'd9, 1'b1, 6'd2, 6'd13,
                        32'hC3);
    deq_valid = 1'b1;
    deq_data = entry_douts[0];
    cdb_valid = 1'b1;
    cdb_tag = 6'd9;
    #1;
    chk("s3 wr_en", 64'(wr_en), 64'h01);
    chk("s3 wr_data0", 64'(wr_data[0]),
        64'(mk(1'b1, 6'd9, 1'b1, 6'd2, 6'd13, 32'hC3)));
    chk("s3 deq_ready", 64'(deq_ready), 64'd0);
    @(negedge clk);
    entry_douts[0] = mk(1'b1, 6'd9, 1'b1, 6'd2, 6'd13,
                        32'hC3);
    deq_data = entry_douts[0];
    cdb_valid = 1'b0;
    #1;
    chk("s3 sel", 64'(deq_sel_onehot), 64'h01);
    @(negedge clk);
    clr();
    #1;
    chk("s3 payload", 64'(iss_payload), 64'hC3);

    // Dependent issue via self-broadcast
    @(negedge clk);
    clr();
    entry_valid = 8'h03;
    entry_douts[0] = mk(1'b1, 6'd1, 1'b1, 6'd2, 6'd7,
                        32'hD0);
    entry_douts[1] = mk(1'b1, 6'd1, 1'b0, 6'd7, 6'd14,
                        32'hD1);
    deq_valid = 1'b1;
    deq_data = entry_douts[0];
    #1;
    chk("s4 N sel", 64'(deq_sel_onehot), 64'h01);
    chk("s4 N wr_en", 64'(wr_en), 64'h00);
    @(negedge clk);
    entry_valid = 8'h01;
    entry_douts[0] = mk(1'b1, 6'd1, 1'b0, 6'd7, 6'd14,
                        32'hD1);
    entry_douts[1] = e_nr;
    deq_data = entry_douts[0];
    #1;
    chk("s4 N+1 bcast_tag", 64'(bcast_tag), 64'd7);
    chk("s4 N+1 wr_en", 64'(wr_en), 64'h01);
    chk("s4 N+1 wr_data0", 64'(wr_data[0]),
        64'(mk(1'b1, 6'd1, 1'b1, 6'd7, 6'd14, 32'hD1)));
    chk("s4 N+1 deq_ready", 64'(deq_ready), 64'd0);
    @(negedge clk);
    entry_douts[0] = mk(1'b1, 6'd1, 1'b1, 6'd7, 6'd14,
                        32'hD1);
    deq_data = entry_douts[0];
    #1;
    chk("s4 N+2 iss_valid", 64'(iss_valid), 64'd0);
    chk("s4 N+2 sel", 64'(deq_sel_onehot), 64'h01);

    // Back-pressure with an eligible entry waiting
    @(negedge clk);
    entry_douts[0] = mk(1'b1, 6'd1, 1'b1, 6'd2, 6'd15,
                        32'hE5);
    deq_data = entry_douts[0];
    iss_ready = 1'b0;
    #1;
    chk("s4 N+3 iss_valid", 64'(iss_valid), 64'd1);
    chk("s4 N+3 payload", 64'(iss_payload), 64'hD1);
    chk("s4 N+3 dst", 64'(iss_dst_tag), 64'd14);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("s5 stall%0d deq_ready", c),
          64'(deq_ready), 64'd0);
      chk($sformatf("s5 stall%0d payload", c),
          64'(iss_payload), 64'hD1);
      chk($sformatf("s5 stall%0d iss_valid", c),
          64'(iss_valid), 64'd1);
    end
    @(negedge clk);
    iss_ready = 1'b1;
    #1;
    chk("s5 release deq_ready", 64'(deq_ready), 64'd1);
    chk("s5 release sel", 64'(deq_sel_onehot), 64'h01);

    // Flush with a valid issue and ready entries
    @(negedge clk);
    clr();
    iss_ready = 1'b0;
    entry_valid = 8'h03;
    entry_douts[0] = mk(1'b1, 6'd1, 1'b1, 6'd2, 6'd16,
                        32'hF6);
    entry_douts[1] = mk(1'b0, 6'd33, 1'b1, 6'd2, 6'd17,
                        32'hF7);
    deq_valid = 1'b1;
    deq_data = entry_douts[0];
    cdb_valid = 1'b1;
    cdb_tag = 6'd33;
    flush = 1'b1;
    #1;
    chk("s5 fire payload", 64'(iss_payload), 64'hE5);
    chk("s5 fire bcast_tag", 64'(bcast_tag), 64'd15);
    chk("s6 flush deq_ready", 64'(deq_ready), 64'd0);
    chk("s6 flush sel", 64'(deq_sel_onehot), 64'h00);
    chk("s6 flush wr_en", 64'(wr_en), 64'h02);
    @(negedge clk);
    clr();
    #1;
    chk("s6 iss_valid", 64'(iss_valid), 64'd0);
    chk("s6 bcast_valid", 64'(bcast_valid), 64'd0);
    chk("s6 payload hold", 64'(iss_payload), 64'hE5);

    // Asynchronous reset mid-operation
    @(negedge clk);
    entry_valid = 8'h01;
    entry_douts[0] = mk(1'b1, 6'd1, 1'b1, 6'd2, 6'd18,
                        32'h77);
    deq_valid = 1'b1;
    deq_data = entry_douts[0];
    #1;
    chk("s7 deq_ready", 64'(deq_ready), 64'd1);
    @(negedge clk);
    entry_douts[0] = mk(1'b1, 6'd1, 1'b1, 6'd2, 6'd19,
                        32'h88);
    deq_data = entry_douts[0];
    iss_ready = 1'b1;
    #1;
    chk("s7 iss_valid", 64'(iss_valid), 64'd1);
    chk("s7 bcast_valid", 64'(bcast_valid), 64'd1);
    chk("s7 pre deq_ready", 64'(deq_ready), 64'd1);
    #1;
    rst_aL = 1'b0;
    #1;
    chk("s7 async iss_valid", 64'(iss_valid), 64'd0);
    chk("s7 async payload", 64'(iss_payload), 64'd0);
    chk("s7 async bcast", 64'(bcast_valid), 64'd0);
    chk("s7 async deq_ready", 64'(deq_ready), 64'd0);
    chk("s7 async sel", 64'(deq_sel_onehot), 64'd0);
    @(negedge clk);
    clr();
    rst_aL = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
